// File: rtl/ps2_key_event_sequencer_if.sv
// Handshake bundle for ps2_key_event_sequencer: raw PS/2 byte strobe in,
// decoded key events (plus held/overflow status) out.
`timescale 1ns/1ps
interface ps2_key_event_sequencer_if;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic       enter_held;
    logic       esc_held;
    logic       overflow;

    modport slave (
        input  ps2_key_data, ps2_key_pressed, evt_ready,
        output evt_valid, evt_code, enter_held, esc_held, overflow
    );
    modport master (
        output ps2_key_data, ps2_key_pressed, evt_ready,
        input  evt_valid, evt_code, enter_held, esc_held, overflow
    );
endinterface

// File: rtl/ps2_key_event_sequencer.sv
// PS/2 scancode decoder feeding a first-word-fall-through event FIFO.
// Define PS2_EXT_KEYS_EN to compile in the E0-prefixed keys (UP, DOWN, keypad ENTER).
`timescale 1ns/1ps
module ps2_key_event_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 2500000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    ps2_key_event_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

`ifdef PS2_EXT_KEYS_EN
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
`else
    typedef enum logic [1:0] {IDLE, BRK} state_t;
`endif

    state_t          state, nstate;
    logic [TW-1:0]   tcnt;
    logic [7:0]      held;          // indexed by event code; bit 0 never set
    logic [2:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            overflow;
    logic [2:0]      code;
    logic            is_make, is_brk;
    logic            strobe, push, push_ok, pop, full;

    function automatic logic [2:0] map_std(input logic [7:0] b);
        case (b)
            8'h5A:   return 3'd1;
            8'h76:   return 3'd2;
            8'h29:   return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

`ifdef PS2_EXT_KEYS_EN
    function automatic logic [2:0] map_ext(input logic [7:0] b);
        case (b)
            8'h5A:   return 3'd1;
            8'h75:   return 3'd4;
            8'h72:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction
`endif

    always_comb begin
        nstate  = state;
        code    = 3'd0;
        is_make = 1'b0;
        is_brk  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ps2_key_data == 8'hF0) nstate = BRK;
`ifdef PS2_EXT_KEYS_EN
                else if (bus.ps2_key_data == 8'hE0) nstate = EXT;
`endif
                else begin
                    code    = map_std(bus.ps2_key_data);
                    is_make = 1'b1;
                end
            end
            BRK: begin
                if (bus.ps2_key_data == 8'hF0) nstate = BRK;
`ifndef PS2_EXT_KEYS_EN
                // without extended keys a stray E0 is simply skipped
                else if (bus.ps2_key_data == 8'hE0) nstate = BRK;
`endif
                else begin
                    code   = map_std(bus.ps2_key_data);
                    is_brk = 1'b1;
                    nstate = IDLE;
                end
            end
`ifdef PS2_EXT_KEYS_EN
            EXT: begin
                if (bus.ps2_key_data == 8'hF0) nstate = EXT_BRK;
                else if (bus.ps2_key_data == 8'hE0) nstate = EXT;
                else begin
                    code    = map_ext(bus.ps2_key_data);
                    is_make = 1'b1;
                    nstate  = IDLE;
                end
            end
            EXT_BRK: begin
                code   = map_ext(bus.ps2_key_data);
                is_brk = 1'b1;
                nstate = IDLE;
            end
`endif
            default: nstate = IDLE;
        endcase
    end

    assign strobe  = bus.ps2_key_pressed;
    assign push    = strobe && is_make && (code != 3'd0) && !held[code];
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = bus.evt_valid && bus.evt_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push && (!full || pop);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state    <= IDLE;
            tcnt     <= '0;
            held     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (strobe) begin
                state <= nstate;
                tcnt  <= '0;
                if (push)        held[code] <= 1'b1;
                else if (is_brk) held[code] <= 1'b0;
            end else if (state != IDLE) begin
                if (tcnt == TW'(PREFIX_TIMEOUT - 1)) begin
                    state <= IDLE;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            if (push_ok) begin
                mem[wptr] <= code;
                wptr      <= wptr + 1'b1;
            end else if (push) begin
                overflow <= 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.evt_valid  = (count != '0);
    assign bus.evt_code   = bus.evt_valid ? mem[rptr] : 3'd0;
    assign bus.enter_held = held[1];
    assign bus.esc_held   = held[2];
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// Bench for ps2_key_event_sequencer (default build, extended keys disabled):
// vector table plus hand-written overflow, timeout and reset sequences.
`timescale 1ns/1ps
module tb_ps2_key_event_sequencer;
    localparam int T = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ps2_key_event_sequencer_if bus();

    ps2_key_event_sequencer #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(T)) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] b;
        logic [2:0] push;
        logic       enter;
        logic       esc;
    } vec_t;

    vec_t       tbl [28];
    logic [2:0] exp_q [$];
    int         checks = 0;
    int         passed = 0;
    int         pops   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // scoreboard: every accepted event is compared against the queue head
    always @(negedge clk) begin
        if (resetn && bus.evt_valid && bus.evt_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL evt_unexpected: got code %0d, expected no event", bus.evt_code);
            end else begin
                chk("evt_code", int'(bus.evt_code), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.ps2_key_data    = b;
        bus.ps2_key_pressed = 1'b1;
        @(posedge clk); #1;
        bus.ps2_key_pressed = 1'b0;
    endtask

    task automatic sb(input logic [7:0] b, input logic [2:0] e);
        if (e != 3'd0) exp_q.push_back(e);
        send(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int n);
        int p0;
        p0 = pops;
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.evt_ready = 1'b0;
        @(negedge clk);
        chk({name, "_pops"}, pops - p0, n);
        chk({name, "_valid_after"}, int'(bus.evt_valid), 0);
    endtask

    // fills FIFO with ENTER, ESC, SPACE, ENTER (ENTER released then re-pressed)
    task automatic fill4();
        sb(8'h5A, 3'd1); sb(8'h76, 3'd2); sb(8'h29, 3'd3);
        sb(8'hF0, 3'd0); sb(8'h5A, 3'd0); sb(8'h5A, 3'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h5A, 3'd1, 1'b1, 1'b0};
        tbl[1]  = '{8'hF0, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{8'h5A, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h76, 3'd2, 1'b0, 1'b1};
        tbl[4]  = '{8'h76, 3'd0, 1'b0, 1'b1};
        tbl[5]  = '{8'h76, 3'd0, 1'b0, 1'b1};
        tbl[6]  = '{8'hF0, 3'd0, 1'b0, 1'b1};
        tbl[7]  = '{8'h76, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{8'h76, 3'd2, 1'b0, 1'b1};
        tbl[9]  = '{8'hF0, 3'd0, 1'b0, 1'b1};
        tbl[10] = '{8'h76, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{8'h29, 3'd3, 1'b0, 1'b0};
        tbl[12] = '{8'h29, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'hF0, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{8'h29, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{8'hE0, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{8'h75, 3'd0, 1'b0, 1'b0};
        tbl[17] = '{8'hE0, 3'd0, 1'b0, 1'b0};
        tbl[18] = '{8'h5A, 3'd1, 1'b1, 1'b0};
        tbl[19] = '{8'hF0, 3'd0, 1'b1, 1'b0};
        tbl[20] = '{8'h5A, 3'd0, 1'b0, 1'b0};
        tbl[21] = '{8'h12, 3'd0, 1'b0, 1'b0};
        tbl[22] = '{8'hF0, 3'd0, 1'b0, 1'b0};
        tbl[23] = '{8'h12, 3'd0, 1'b0, 1'b0};
        tbl[24] = '{8'h5A, 3'd1, 1'b1, 1'b0};
        tbl[25] = '{8'hF0, 3'd0, 1'b1, 1'b0};
        tbl[26] = '{8'hF0, 3'd0, 1'b1, 1'b0};
        tbl[27] = '{8'h5A, 3'd0, 1'b0, 1'b0};

        bus.ps2_key_data    = 8'h00;
        bus.ps2_key_pressed = 1'b0;
        bus.evt_ready       = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_evt_valid", int'(bus.evt_valid), 0);
        chk("rst_evt_code", int'(bus.evt_code), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_enter_held", int'(bus.enter_held), 0);
        chk("rst_esc_held", int'(bus.esc_held), 0);

        // decode table, consumer always ready
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 28; i++) begin
            sb(tbl[i].b, tbl[i].push);
            @(negedge clk);
            chk($sformatf("tbl%0d_enter_held", i), int'(bus.enter_held), int'(tbl[i].enter));
            chk($sformatf("tbl%0d_esc_held", i), int'(bus.esc_held), int'(tbl[i].esc));
            if (tbl[i].push != 3'd0)
                chk($sformatf("tbl%0d_latency_valid", i), int'(bus.evt_valid), 1);
        end
        repeat (3) @(negedge clk);
        chk("tbl_events_all_seen", exp_q.size(), 0);
        bus.evt_ready = 1'b0;

        // overflow: fifth event dropped while nothing pops
        do_reset();
        fill4();
        @(negedge clk);
        chk("ovf_before", int'(bus.overflow), 0);
        chk("ovf_head_code", int'(bus.evt_code), 1);
        sb(8'hF0, 3'd0);
        sb(8'h76, 3'd0);
        sb(8'h76, 3'd0);
        @(negedge clk);
        chk("ovf_set", int'(bus.overflow), 1);
        drain("ovf_drain", 4);
        chk("ovf_sticky", int'(bus.overflow), 1);

        // full FIFO with simultaneous push and pop
        do_reset();
        @(negedge clk);
        chk("rst2_overflow", int'(bus.overflow), 0);
        fill4();
        sb(8'hF0, 3'd0);
        sb(8'h76, 3'd0);
        @(posedge clk); #1;
        exp_q.push_back(3'd2);
        bus.ps2_key_data    = 8'h76;
        bus.ps2_key_pressed = 1'b1;
        bus.evt_ready       = 1'b1;
        @(posedge clk); #1;
        bus.ps2_key_pressed = 1'b0;
        bus.evt_ready       = 1'b0;
        @(negedge clk);
        chk("pp_overflow", int'(bus.overflow), 0);
        chk("pp_head_code", int'(bus.evt_code), 2);
        drain("pp_drain", 4);

        // prefix timeout: T-1 idle cycles keeps BRK, T idle cycles returns to IDLE
        do_reset();
        bus.evt_ready = 1'b1;
        send(8'hF0);
        repeat (T - 2) @(posedge clk);
        sb(8'h29, 3'd0);
        send(8'hF0);
        repeat (T - 1) @(posedge clk);
        sb(8'h29, 3'd3);
        repeat (4) @(negedge clk);
        chk("timeout_events_seen", exp_q.size(), 0);
        sb(8'hF0, 3'd0);
        sb(8'h29, 3'd0);

        // reset with three queued events
        bus.evt_ready = 1'b0;
        sb(8'h5A, 3'd1); sb(8'h76, 3'd2); sb(8'h29, 3'd3);
        @(negedge clk);
        chk("q3_valid", int'(bus.evt_valid), 1);
        do_reset();
        @(negedge clk);
        chk("q3_rst_valid", int'(bus.evt_valid), 0);
        chk("q3_rst_code", int'(bus.evt_code), 0);
        chk("q3_rst_enter_held", int'(bus.enter_held), 0);

        // reset mid-prefix with a coincident strobe
        send(8'hF0);
        @(posedge clk); #1;
        resetn              = 1'b0;
        bus.ps2_key_data    = 8'h5A;
        bus.ps2_key_pressed = 1'b1;
        @(posedge clk); #1;
        resetn              = 1'b1;
        bus.ps2_key_pressed = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_strobe_valid", int'(bus.evt_valid), 0);
        chk("rst_strobe_enter_held", int'(bus.enter_held), 0);
        bus.evt_ready = 1'b1;
        sb(8'h5A, 3'd1);
        @(negedge clk);
        chk("post_rst_enter_held", int'(bus.enter_held), 1);
        repeat (3) @(negedge clk);
        chk("post_rst_events_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_sequencer.md
PS2_KEY_EVENT_SEQUENCER -- requirements
Module: ps2_key_event_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, at least 2.
REQ-002 Parameter PREFIX_TIMEOUT, default 2500000, CLOCK_50 cycles (50 ms) allowed between a prefix byte and its next byte.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 ps2_key_data  in  8  received scancode byte, valid only when ps2_key_pressed is high.
REQ-006 ps2_key_pressed  in  1  one-cycle byte strobe from the PS/2 controller.
REQ-007 evt_valid  out  1  FIFO non-empty; evt_code is valid.
REQ-008 evt_code  out  3  head event code: 1 ENTER, 2 ESC, 3 SPACE, 4 UP, 5 DOWN; 0 when empty.
REQ-009 evt_ready  in  1  consumer accept; an event pops when evt_valid and evt_ready are both high.
REQ-010 enter_held, esc_held  out  1 each  key currently held down (make seen, break not yet seen).
REQ-011 overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Function
REQ-012 Decode FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); transitions only on ps2_key_pressed.
REQ-013 IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, decoded, then stay in IDLE.
REQ-014 BRK: F0 -> stay; any other byte is a break code, decoded, then -> IDLE.
REQ-015 EXT: F0 -> EXT_BRK; E0 -> stay; any other byte is an extended make code, decoded, then -> IDLE.
REQ-016 EXT_BRK: any byte is an extended break code, decoded, then -> IDLE.
REQ-017 Non-extended map: 5A ENTER, 76 ESC, 29 SPACE. Extended map: 5A ENTER, 75 UP, 72 DOWN. All other bytes are unmapped and ignored.
REQ-018 Make of a mapped key not held: set its held bit and push its code in the same cycle.
REQ-019 Make of a mapped key already held (typematic repeat): no push, held bit stays set.
REQ-020 Break of a mapped key: clear its held bit, no push; break of a key not held has no effect.
REQ-021 Latency: strobe in cycle N with an empty FIFO gives evt_valid=1 and the correct evt_code in cycle N+1; FIFO is first-word-fall-through.
REQ-022 Push while full and no pop: drop the new event, set overflow; FIFO contents unchanged.
REQ-023 Push and pop in the same cycle while full: both take effect, count unchanged, no overflow.
REQ-024 Pop while empty is ignored; read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 Prefix timeout: a counter runs while in BRK, EXT or EXT_BRK and clears on each strobe; reaching PREFIX_TIMEOUT forces IDLE with no decode.
REQ-026 enter_held and esc_held drive directly from their held bits, registered.

Reset
REQ-027 resetn=0 at a clock edge forces: FSM to IDLE, timeout counter to 0, FIFO empty (pointers 0), all held bits 0, overflow 0, evt_valid 0, evt_code 0.
REQ-028 Reset mid-prefix or mid-FIFO discards all pending state; a strobe coincident with reset is ignored.
REQ-029 overflow clears only on reset.

Configuration
REQ-030 Macro PS2_EXT_KEYS_EN defined: EXT and EXT_BRK states and the extended map are compiled in.
REQ-031 Macro PS2_EXT_KEYS_EN undefined: E0 is an unmapped byte ignored in IDLE and BRK; EXT and EXT_BRK do not exist; the following byte decodes with the non-extended map, so E0 5A gives ENTER and E0 75 is ignored; codes 4 and 5 never appear.

Verification
REQ-032 Bytes 5A, F0 5A with evt_ready=1 -> exactly one ENTER event; enter_held 1 after 5A, 0 after F0 5A.
REQ-033 Bytes 76 76 76 (repeat), then F0 76, then 76 -> exactly two ESC events.
REQ-034 evt_ready=0, five distinct make codes with DEPTH=4 -> four events queued, overflow=1, first four codes popped in order once ready rises.
REQ-035 Full FIFO plus a push and pop in the same cycle -> count remains 4, overflow stays 0.
REQ-036 With PS2_EXT_KEYS_EN: E0 75 -> UP; E0 F0 75 -> no event. Without the macro: E0 75 -> no event.
REQ-037 F0 followed by PREFIX_TIMEOUT idle cycles, then 29 -> SPACE event pushed as a make code; resetn=0 with 3 queued events -> evt_valid 0 in the next cycle.
